// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: shared types and constants for the multi-cycle ALU.
//   op_e     - 3-bit operation encoding (OP_ADD .. OP_MUL)
//   state_e  - control FSM states (IDLE / MUL / DONE)
//   FLAG_*   - bit positions inside out_flags
package mc_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_NEG = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_SLL = 3'b100,
      OP_SRL = 3'b101,
      OP_SRA = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_SIGN  = 1;
   localparam int FLAG_CARRY = 2;

endpackage

// File: rtl/mc_alu_mul.sv
// mc_alu_mul: iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset (aborts a running multiply)
//   start_i   - load operands and begin; takes WIDTH further cycles
//   a_i, b_i  - multiplicand / multiplier
//   done_o    - high during the final iteration cycle
//   product_o - 2*WIDTH product; valid in the cycle done_o is high (includes
//               the final partial sum, so the caller can register it that edge)
module mc_alu_mul
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               run_q, run_d;
   logic [2*WIDTH-1:0] sum_s;

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   end

   // Iteration control: load on start, step while running, stop after WIDTH steps.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i) begin
         acc_d    = {(2*WIDTH){1'b0}};
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         cnt_d    = {CW{1'b0}};
         run_d    = 1'b1;
      end else if (run_q) begin
         acc_d    = sum_s;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (cnt_q == CW'(WIDTH-1)) begin
            run_d = 1'b0;
         end else begin
            run_d = 1'b1;
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // Multiplier state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= {(2*WIDTH){1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         run_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

   assign done_o    = run_q && (cnt_q == CW'(WIDTH-1));
   assign product_o = sum_s;

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshakes on input and output.
// Optional feature macro: MC_ALU_MUL_EN (iterative multiplier for op 111).
// Ports:
//   clk, rst_n          - rising-edge clock, synchronous active-low reset
//   in_valid / in_ready - input handshake; operands captured on the accept edge
//   in_a, in_b, op      - operands and 3-bit op (see mc_alu_pkg::op_e)
//   out_valid/out_ready - output handshake; result held until accepted
//   out_result          - registered result
//   out_flags           - [0] zero, [1] sign, [2] carry/overflow
//   busy                - high while the multiplier iterates
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_flags,
   output logic             busy
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       flags_q, flags_d;
   op_e              op_s;
   logic             accept_s;
   logic [WIDTH:0]   sum_s;
   logic [SW-1:0]    shamt_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_carry_s;

   assign op_s     = op_e'(op);
   assign accept_s = (state_q == ST_IDLE) && in_valid;
   assign sum_s    = {1'b0, in_a} + {1'b0, in_b};
   assign shamt_s  = in_b[SW-1:0];

`ifdef MC_ALU_MUL_EN
   logic               mul_start_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_prod_s;

   assign mul_start_s = accept_s && (op_s == OP_MUL);

   mc_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start_s),
      .a_i       (in_a),
      .b_i       (in_b),
      .done_o    (mul_done_s),
      .product_o (mul_prod_s)
   );
`endif

   // Single-cycle operations evaluated directly on the presented operands.
   always_comb begin
      alu_res_s   = {WIDTH{1'b0}};
      alu_carry_s = 1'b0;
      case (op_s)
         OP_ADD: begin
            alu_res_s   = sum_s[WIDTH-1:0];
            alu_carry_s = sum_s[WIDTH];
         end
         OP_NEG:  alu_res_s = ~in_b + ONE;
         OP_AND:  alu_res_s = in_a & in_b;
         OP_XOR:  alu_res_s = in_a ^ in_b;
         OP_SLL:  alu_res_s = in_a << shamt_s;
         OP_SRL:  alu_res_s = in_a >> shamt_s;
         OP_SRA:  alu_res_s = $signed(in_a) >>> shamt_s;
         // Without the multiplier op 111 yields 0; with it, this value is
         // overwritten when the multiply finishes.
         OP_MUL:  alu_res_s = {WIDTH{1'b0}};
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state logic of the control FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
`ifdef MC_ALU_MUL_EN
               if (op_s == OP_MUL) begin
                  state_d = ST_MUL;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
`ifdef MC_ALU_MUL_EN
            if (mul_done_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MUL;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Result/flag capture: on accept for single-cycle ops, on the last multiply step.
   always_comb begin
      result_d = result_q;
      flags_d  = flags_q;
      if (accept_s) begin
         result_d              = alu_res_s;
         flags_d[FLAG_ZERO]    = (alu_res_s == {WIDTH{1'b0}});
         flags_d[FLAG_SIGN]    = alu_res_s[WIDTH-1];
         flags_d[FLAG_CARRY]   = alu_carry_s;
      end
`ifdef MC_ALU_MUL_EN
      else if ((state_q == ST_MUL) && mul_done_s) begin
         result_d              = mul_prod_s[WIDTH-1:0];
         flags_d[FLAG_ZERO]    = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
         flags_d[FLAG_SIGN]    = mul_prod_s[WIDTH-1];
         flags_d[FLAG_CARRY]   = |mul_prod_s[2*WIDTH-1:WIDTH];
      end
`endif
      else begin
         result_d = result_q;
         flags_d  = flags_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= {WIDTH{1'b0}};
         flags_q  <= 3'b000;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // Handshake/status outputs decoded from the registered state.
   always_comb begin
      in_ready   = (state_q == ST_IDLE);
      out_valid  = (state_q == ST_DONE);
      busy       = (state_q == ST_MUL);
      out_result = result_q;
      out_flags  = flags_q;
   end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mc_alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .op         (op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .busy       (busy)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  o;
      int          stall;
      logic [31:0] exp_r;
      logic [2:0]  exp_f;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model from the arithmetic definition of each op.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        output logic [31:0] r, output logic [2:0] f,
                        output int lat, output int bz);
      logic [63:0] s;
      int sh;
      logic c;
      sh  = int'(b % 32);
      c   = 1'b0;
      lat = 1;
      bz  = 0;
      r   = 32'd0;
      case (o)
         3'd0: begin s = {32'd0, a} + {32'd0, b}; r = s[31:0]; c = s[32]; end
         3'd1: r = 32'd0 - b;
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: r = a << sh;
         3'd5: r = a >> sh;
         3'd6: begin
            r = a >> sh;
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
         end
         default: begin
`ifdef MC_ALU_MUL_EN
            s   = {32'd0, a} * {32'd0, b};
            r   = s[31:0];
            c   = (s[63:32] != 32'd0);
            lat = 33;
            bz  = 32;
`else
            r = 32'd0;
`endif
         end
      endcase
      f = {c, r[31], (r == 32'd0)};
   endtask

   // One full transaction: present, accept, wait for result, stall, drain.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        input int stall, input logic [31:0] xr, input logic [2:0] xf,
                        input string tag);
      logic [31:0] er;
      logic [2:0]  ef;
      int elat, ebz, lat, bz, n;
      model(a, b, o, er, ef, elat, ebz);
      @(negedge clk);
      in_a = a; in_b = b; op = o; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; op = 3'($urandom);
      lat = 0; bz = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) bz++;
      end while (!out_valid && lat < 100);
      chk({tag, "_latency"}, 64'(lat), 64'(elat));
      chk({tag, "_busy_cycles"}, 64'(bz), 64'(ebz));
      chk({tag, "_result"}, 64'(out_result), 64'(xr));
      chk({tag, "_flags"}, 64'(out_flags), 64'(xf));
      chk({tag, "_model"}, {29'd0, ef, er}, {29'd0, xf, xr});
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; in_a = $urandom; in_b = $urandom; op = 3'($urandom);
         @(negedge clk);
         chk({tag, "_stall_result"}, 64'(out_result), 64'(xr));
         chk({tag, "_stall_flags"}, 64'(out_flags), 64'(xf));
         chk({tag, "_stall_busy_ready"}, {62'd0, in_ready, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ready_after_out"}, {62'd0, in_ready, out_valid}, 64'd2);
   endtask

   vec_t tbl[$];

   initial begin
      logic [31:0] ra, rb, mr;
      logic [2:0]  ro, mf;
      int ml, mb;
      bit seen;

      rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; op = 3'd0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(out_result), 64'd0);
      chk("reset_flags", 64'(out_flags), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);

      tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 0, 32'h0000_0000, 3'b101});
      tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 0, 32'h8000_0000, 3'b010});
      tbl.push_back('{32'h8000_0000, 32'h0000_0024, 3'd6, 0, 32'hF800_0000, 3'b010});
      tbl.push_back('{32'h8000_0000, 32'h0000_0024, 3'd5, 0, 32'h0800_0000, 3'b000});
      tbl.push_back('{32'h1234_5678, 32'h0000_0001, 3'd1, 1, 32'hFFFF_FFFF, 3'b010});
      tbl.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 0, 32'h00F0_00F0, 3'b000});
      tbl.push_back('{32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd3, 2, 32'h0000_0000, 3'b001});
      tbl.push_back('{32'h0000_0001, 32'h0000_003F, 3'd4, 0, 32'h8000_0000, 3'b010});
      tbl.push_back('{32'h0000_0000, 32'h0000_0000, 3'd1, 0, 32'h0000_0000, 3'b001});
`ifdef MC_ALU_MUL_EN
      tbl.push_back('{32'h0001_0000, 32'h0001_0000, 3'd7, 0, 32'h0000_0000, 3'b101});
      tbl.push_back('{32'h0000_0007, 32'h0000_0006, 3'd7, 5, 32'h0000_002A, 3'b000});
`else
      tbl.push_back('{32'h0000_0007, 32'h0000_0006, 3'd7, 0, 32'h0000_0000, 3'b001});
      tbl.push_back('{32'h0001_0000, 32'h0001_0000, 3'd7, 5, 32'h0000_0000, 3'b001});
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].stall, tbl[i].exp_r, tbl[i].exp_f,
               $sformatf("vec%0d", i));
      end

`ifdef MC_ALU_MUL_EN
      // Reset during a multiply discards it.
      @(negedge clk);
      in_a = 32'd7; in_b = 32'd6; op = 3'd7; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); seen |= out_valid; end
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin @(negedge clk); seen |= out_valid; end
      chk("abort_no_valid", 64'(seen), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
`endif
      apply(32'd2, 32'd3, 3'd0, 0, 32'd5, 3'b000, "add_after_abort");

      for (int i = 0; i < 150; i++) begin
         ra = $urandom; rb = $urandom; ro = 3'($urandom_range(0, 7));
         if (i % 5 == 0) rb = 32'($urandom_range(0, 70));
         model(ra, rb, ro, mr, mf, ml, mb);
         apply(ra, rb, ro, $urandom_range(0, 2), mr, mf, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
# mc_alu

Multi-cycle, width-parametrised ALU for the KGP-miniRISC datapath, successor to the single-cycle combinational ALU. It keeps the 3-bit op encoding, adds a registered valid/ready handshake on both sides and an optional iterative shift-add multiplier. Zero/sign flags are computed from the result, not the operand. It sits between the register-read stage and writeback, and the control FSM stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, default 32: operand/result width. Must be ≥ 4 and a power of two.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  operands and op presented
- `in_ready`  out  1  block can accept an operation
- `in_a`  in  WIDTH  operand A; treated as signed for `sra`
- `in_b`  in  WIDTH  operand B; low `$clog2(WIDTH)` bits are the shift amount for shifts
- `op`  in  3  000 add, 001 negate B, 010 and, 011 xor, 100 sll, 101 srl, 110 sra, 111 mul
- `out_valid`  out  1  result and flags valid
- `out_ready`  in  1  consumer accepts the result
- `out_result`  out  WIDTH  registered result
- `out_flags`  out  3  [0] zero, [1] sign (result MSB), [2] carry/overflow
- `busy`  out  1  high in `MUL` state

## Operation
- FSM states:
  - `IDLE`: `in_ready`=1. On `in_valid`: ops 000–110 go to `DONE`; op 111 goes to `MUL`.
  - `MUL`: multiplies for WIDTH cycles, then goes to `DONE`.
  - `DONE`: holds the output. On `out_ready` returns to `IDLE`.
- Operands and op are captured only on the accept edge. Input changes after accept have no effect.
- Add: WIDTH-bit sum. flags[2] = carry out of bit WIDTH-1.
- Negate: `~in_b + 1`. flags[2] = 0.
- And, xor: bitwise. flags[2] = 0.
- Shifts:
  - Amount = `in_b[$clog2(WIDTH)-1:0]`, so upper bits are ignored (shift by 36 at WIDTH=32 equals shift by 4).
  - `sra` replicates `in_a` MSB.
  - flags[2] = 0.
- Mul:
  - Unsigned shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
  - Result = low WIDTH bits.
  - flags[2] = 1 iff the high WIDTH bits are nonzero.
- flags[0] and flags[1] always derive from the final `out_result`.

## Timing
- Reset, checked the first edge with `rst_n`=0: state `IDLE`, `out_valid`=0, `out_result`=0, `out_flags`=0, `busy`=0, iteration counter 0.
  - `in_ready`=1 from the first cycle after reset is released.
- Ops 000–110: accepted at edge N; `out_valid`=1 after edge N+1.
- Mul: `busy`=1 for WIDTH cycles; `out_valid`=1 WIDTH+1 edges after accept.
- `out_result` and `out_flags` are stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in `MUL` and `DONE`, so an `in_valid` there is not accepted and the upstream holds its data.
- No bypass: an output accept at edge M gives `in_ready`=1 after edge M. Peak throughput is one op per 2 cycles.
- Reset mid-`MUL` or mid-`DONE` aborts the operation: the pending result is discarded and no `out_valid` pulse occurs.

## Configuration
- `MC_ALU_MUL_EN` defined:
  - Op 111 runs the iterative multiplier.
  - `MUL` state, 2·WIDTH accumulator and counter are present.
- `MC_ALU_MUL_EN` undefined:
  - No multiplier logic; `MUL` state is unreachable and `busy` is tied 0.
  - Op 111 is single-cycle with result 0 and flags = 3'b001.

## Structure
- Package `mc_alu_pkg` holds:
  - the op encoding enum (`OP_ADD` … `OP_MUL`)
  - the FSM state enum
  - flag bit index constants `FLAG_ZERO`=0, `FLAG_SIGN`=1, `FLAG_CARRY`=2
- Sub-module `mc_alu_mul`: the iterative multiplier (start/done, counter, accumulator), instantiated only under `MC_ALU_MUL_EN`.
- The single-cycle ops stay in the top as combinational logic feeding the result register.

## Test plan
All scenarios use WIDTH=32.
- Add 0xFFFFFFFF + 0x00000001 → result 0x00000000, flags 3'b101; `out_valid` one cycle after accept.
- Sra 0x80000000, B=0x24 (shift by 4) → result 0xF8000000, flags 3'b010. Same operands with srl → 0x08000000, flags 3'b000.
- Mul 0x00010000 × 0x00010000 (macro on) → result 0, flags 3'b101. `busy` high for 32 cycles; `out_valid` 33 edges after accept.
- Mul 7 × 6 with `out_ready` held low 5 cycles → `out_result`=42 and flags 3'b000 stable throughout. `in_ready`=0 and a concurrent `in_valid` is ignored. After `out_ready` goes high, `in_ready`=1 on the next cycle.
- `rst_n` low at cycle 10 of a mul → `out_valid` never asserts for it; `in_ready`=1 after release; a following add 2+3 returns 5.
- Macro off, op 111 with 7, 6 → result 0, flags 3'b001 one cycle after accept; `busy` stays 0.
